// File: rtl/rx_fct_credit_if.sv
// rtl/rx_fct_credit_if.sv - link-side signal bundle for the RX flow-control credit block
//
// Signals:
//   enable_rx          link running; low holds the credit block cleared
//   fifo_free_space    free entries in the local RX FIFO (0..64)
//   got_nchar          one-cycle pulse per received N-Char
//   fct_sent           TX side has put the requested FCT on the wire
//   send_fct_req       request to TX side to send one FCT
//   credit_outstanding N-Chars the far end may still send
//   credit_error       sticky: N-Char arrived with no credit outstanding
//
// The master drives the link-side inputs; the slave is the credit block.
interface rx_fct_credit_if;
    logic       enable_rx;
    logic [6:0] fifo_free_space;
    logic       got_nchar;
    logic       fct_sent;
    logic       send_fct_req;
    logic [5:0] credit_outstanding;
    logic       credit_error;

    modport master (
        output enable_rx,
        output fifo_free_space,
        output got_nchar,
        output fct_sent,
        input  send_fct_req,
        input  credit_outstanding,
        input  credit_error
    );

    modport slave (
        input  enable_rx,
        input  fifo_free_space,
        input  got_nchar,
        input  fct_sent,
        output send_fct_req,
        output credit_outstanding,
        output credit_error
    );
endinterface

// File: rtl/rx_fct_credit.sv
// rtl/rx_fct_credit.sv - RX flow-control credit tracker and FCT request FSM
//
// Ports:
//   pclk_rx   clock, all state changes on its rising edge
//   reset_rx  asynchronous active-high reset
//   bus       rx_fct_credit_if.slave (link enable, FIFO space, N-Char pulse,
//             FCT handshake, credit count and credit error)
//
// Parameters:
//   FCT_CREDIT  N-Chars granted to the far end per FCT
//   MAX_CREDIT  ceiling on outstanding credit
module rx_fct_credit #(
    parameter int unsigned FCT_CREDIT = 8,
    parameter int unsigned MAX_CREDIT = 56
) (
    input  logic pclk_rx,
    input  logic reset_rx,
    rx_fct_credit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic [5:0] credit_q, credit_d;
    logic       err_q, err_d;

    logic [6:0] credit_ext;
    logic [6:0] grant_sum;
    logic       can_grant;
    logic       grant;
    logic [5:0] credit_mid;

    // Compared at 7 bits: credit + FCT_CREDIT reaches 64 at the ceiling,
    // which does not fit the 6-bit credit register.
    assign credit_ext = {1'b0, credit_q};
    assign grant_sum  = credit_ext + 7'(FCT_CREDIT);
    assign can_grant  = (bus.fifo_free_space >= grant_sum) &&
                        (grant_sum <= 7'(MAX_CREDIT));

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        grant      = 1'b0;
        credit_mid = credit_q;
        credit_d   = credit_q;

        case (state_q)
            ST_IDLE: if (can_grant) state_d = ST_REQ;
            ST_REQ: begin
                if (bus.fct_sent) begin
                    state_d = ST_ACK;
                    grant   = 1'b1;
                end
            end
            ST_ACK:  if (!bus.fct_sent) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The grant is applied before the N-Char is consumed, so an N-Char
        // arriving with zero credit on the grant edge is covered by it.
        // No overflow: a grant only starts when credit + FCT_CREDIT fits
        // under MAX_CREDIT and credit can only fall while the FCT is pending.
        if (grant) credit_mid = credit_q + 6'(FCT_CREDIT);

        if (bus.got_nchar) begin
            if (credit_mid != 6'd0) begin
                credit_d = credit_mid - 6'd1;
            end else begin
                credit_d = credit_mid;
                err_d    = 1'b1;
            end
        end else begin
            credit_d = credit_mid;
        end

        // Link down overrides everything, including a handshake in flight.
        if (!bus.enable_rx) begin
            state_d  = ST_IDLE;
            credit_d = 6'd0;
            err_d    = 1'b0;
        end

        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge pclk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            credit_q <= 6'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign bus.send_fct_req       = req_q;
    assign bus.credit_outstanding = credit_q;
    assign bus.credit_error       = err_q;

endmodule

// File: tb/tb_rx_fct_credit.sv
// tb/tb_rx_fct_credit.sv - self-checking bench for rx_fct_credit
module tb_rx_fct_credit;

    logic pclk_rx  = 1'b0;
    logic reset_rx = 1'b1;

    rx_fct_credit_if bus ();

    rx_fct_credit #(.FCT_CREDIT(8), .MAX_CREDIT(56)) dut (
        .pclk_rx  (pclk_rx),
        .reset_rx (reset_rx),
        .bus      (bus)
    );

    always #5 pclk_rx = ~pclk_rx;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       en;
        logic [6:0] free;
        logic       nc;
        logic       snt;
        logic       req;
        int         cr;
        logic       err;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply inputs away from the edge, clock once, sample 1 ns after the edge.
    task automatic step(input logic en, input logic [6:0] free, input logic nc, input logic snt);
        bus.enable_rx       = en;
        bus.fifo_free_space = free;
        bus.got_nchar       = nc;
        bus.fct_sent        = snt;
        @(posedge pclk_rx);
        #1;
    endtask

    task automatic chk3(input string nm, input logic req, input int cr, input logic err);
        chk({nm, ".req"}, int'(bus.send_fct_req), int'(req));
        chk({nm, ".credit"}, int'(bus.credit_outstanding), cr);
        chk({nm, ".err"}, int'(bus.credit_error), int'(err));
    endtask

    // Reference model: handshake phase 0 = nothing pending, 1 = FCT requested,
    // 2 = FCT on the wire; credit kept as a plain integer.
    int m_ph, m_cr;
    bit m_err;

    task automatic model(input logic en, input int free, input logic nc, input logic snt);
        int granted;
        int avail;
        granted = 0;
        if (!en) begin
            m_ph = 0; m_cr = 0; m_err = 0;
        end else begin
            if (m_ph == 0) begin
                if (free >= m_cr + 8 && m_cr + 8 <= 56) m_ph = 1;
            end else if (m_ph == 1) begin
                if (snt) begin m_ph = 2; granted = 8; end
            end else begin
                if (!snt) m_ph = 0;
            end
            avail = m_cr + granted;
            if (nc) begin
                if (avail > 0) avail = avail - 1;
                else m_err = 1;
            end
            m_cr = avail;
        end
    endtask

    initial begin
        int  nreq, k, wait_c;
        logic snt, prev_req;
        int  prev_cr;

        bus.enable_rx       = 1'b0;
        bus.fifo_free_space = 7'd64;
        bus.got_nchar       = 1'b0;
        bus.fct_sent        = 1'b0;

        // Reset state without any clock edge having occurred.
        #2;
        chk3("reset", 1'b0, 0, 1'b0);
        @(negedge pclk_rx);
        reset_rx = 1'b0;

        //          en    free   nc    snt   req   cr   err
        vt[0]  = '{1'b0, 7'd64, 1'b0, 1'b0, 1'b0, 0,  1'b0};
        vt[1]  = '{1'b1, 7'd64, 1'b0, 1'b0, 1'b1, 0,  1'b0};
        vt[2]  = '{1'b1, 7'd64, 1'b1, 1'b1, 1'b0, 7,  1'b0}; // grant + nchar at zero
        vt[3]  = '{1'b1, 7'd64, 1'b0, 1'b1, 1'b0, 7,  1'b0};
        vt[4]  = '{1'b1, 7'd64, 1'b0, 1'b0, 1'b0, 7,  1'b0};
        vt[5]  = '{1'b1, 7'd14, 1'b0, 1'b0, 1'b0, 7,  1'b0}; // 14 < 7+8
        vt[6]  = '{1'b1, 7'd15, 1'b0, 1'b0, 1'b1, 7,  1'b0}; // 15 == 7+8
        vt[7]  = '{1'b1, 7'd15, 1'b0, 1'b1, 1'b0, 15, 1'b0};
        vt[8]  = '{1'b1, 7'd15, 1'b0, 1'b0, 1'b0, 15, 1'b0};
        vt[9]  = '{1'b0, 7'd15, 1'b0, 1'b0, 1'b0, 0,  1'b0};
        vt[10] = '{1'b1, 7'd0,  1'b1, 1'b0, 1'b0, 0,  1'b1}; // underflow
        vt[11] = '{1'b1, 7'd0,  1'b0, 1'b0, 1'b0, 0,  1'b1}; // sticky
        vt[12] = '{1'b0, 7'd0,  1'b0, 1'b0, 1'b0, 0,  1'b0};

        for (int i = 0; i < 13; i++) begin
            step(vt[i].en, vt[i].free, vt[i].nc, vt[i].snt);
            chk3($sformatf("vec%0d", i), vt[i].req, vt[i].cr, vt[i].err);
        end

        // Fill to the ceiling, TX answering 2 cycles after each request.
        nreq = 0; k = 0; wait_c = 0; snt = 1'b0;
        prev_req = bus.send_fct_req; prev_cr = int'(bus.credit_outstanding);
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (bus.send_fct_req) begin
                if (!snt) begin
                    wait_c++;
                    if (wait_c >= 2) snt = 1'b1;
                end
            end else begin
                snt = 1'b0; wait_c = 0;
            end
            step(1'b1, 7'd64, 1'b0, snt);
            if (bus.send_fct_req && !prev_req) nreq++;
            if (int'(bus.credit_outstanding) != prev_cr) begin
                k++;
                chk("fill.step", int'(bus.credit_outstanding), 8 * k);
            end
            prev_req = bus.send_fct_req;
            prev_cr  = int'(bus.credit_outstanding);
        end
        chk("fill.nfct", nreq, 7);
        chk3("fill.end", 1'b0, 56, 1'b0);

        // Drain 10 N-Chars from the ceiling; a request reopens on the way down.
        for (int i = 0; i < 10; i++) step(1'b1, 7'd64, 1'b1, 1'b0);
        chk3("drain", 1'b1, 46, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b1);
        chk3("drain.grant", 1'b0, 54, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b0);
        chk3("drain.ceiling", 1'b0, 54, 1'b0);

        // Free-space boundary at credit 8.
        step(1'b0, 7'd64, 1'b0, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b0);
        step(1'b1, 7'd15, 1'b0, 1'b1);
        step(1'b1, 7'd15, 1'b0, 1'b0);
        step(1'b1, 7'd15, 1'b0, 1'b0);
        chk3("space15", 1'b0, 8, 1'b0);
        step(1'b1, 7'd16, 1'b0, 1'b0);
        chk3("space16", 1'b1, 8, 1'b0);

        // Link drop mid-handshake at credit 24.
        step(1'b1, 7'd64, 1'b0, 1'b1);
        step(1'b1, 7'd64, 1'b0, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b1);
        chk3("ack24", 1'b0, 24, 1'b0);
        step(1'b0, 7'd64, 1'b0, 1'b1);
        chk3("drop", 1'b0, 0, 1'b0);
        step(1'b1, 7'd0, 1'b0, 1'b1);
        chk3("idle_sent_ignored", 1'b0, 0, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b1);
        step(1'b1, 7'd64, 1'b0, 1'b0);
        step(1'b1, 7'd64, 1'b0, 1'b0);
        chk3("req8", 1'b1, 8, 1'b0);

        // Asynchronous reset mid-request, checked before the next edge.
        reset_rx = 1'b1;
        #1;
        chk3("async_rst", 1'b0, 0, 1'b0);
        step(1'b0, 7'd64, 1'b0, 1'b0);
        reset_rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 7'd64, 1'b0, 1'b0);
            chk("post_rst.noreq", int'(bus.send_fct_req), 0);
        end
        step(1'b1, 7'd64, 1'b0, 1'b0);
        chk("post_rst.req", int'(bus.send_fct_req), 1);

        // Randomised run against the reference model.
        step(1'b0, 7'd0, 1'b0, 1'b0);
        m_ph = 0; m_cr = 0; m_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       r_en, r_nc, r_snt;
            logic [6:0] r_free;
            r_en   = ($urandom_range(0, 31) != 0);
            r_free = 7'($urandom_range(0, 64));
            r_nc   = ($urandom_range(0, 2) == 0);
            r_snt  = ($urandom_range(0, 1) == 1);
            model(r_en, int'(r_free), r_nc, r_snt);
            step(r_en, r_free, r_nc, r_snt);
            chk3("rand", (m_ph == 1), m_cr, m_err);
            if (m_cr > 56) chk("rand.ceiling", m_cr, 56);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
